fetch_frontend: RTL and testbench
=================================

Name: fetch_frontend

Overview:
- Instruction front end of the out-of-order RV32I core: direct-mapped instruction cache, PC/fetch sequencer, and a predecoder for control-flow instructions.
- Requests cache lines from memctrl and queries/updates the branch predictor.
- Hands one instruction plus its PC and prediction bit to the decoder per accepted handshake.
- Redirects on JALR resolution and branch mispredict reported by the ROB.

Parameters:
CACHE_WIDTH, 3, log2 of cache line count (8 lines, one 32-bit word per line)
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state
icache_to_memctrl  out  1  miss request valid, held until received
address  out  32  word-aligned miss address
received  in  1  memctrl accepted request
memctrl_to_icache  in  1  one-cycle pulse: inst_in valid
inst_in  in  32  fetched word
query  out  1  predictor lookup valid
pc_to_predictor  out  32  PC of branch being predicted
predict  in  1  predictor answer, combinational same cycle (1 = taken)
update  out  1  one-cycle predictor training pulse
update_pc  out  32  branch PC being trained
update_result  out  1  actual outcome
inst  out  32  instruction to decoder
pc_to_decoder  out  32  its PC
inst_valid  out  1  inst/pc_to_decoder/predict_result valid
predict_result  out  1  prediction bit used for this instruction (0 for non-branches)
dec_received  in  1  decoder/ROB accepted current instruction
jalr_finish  in  1  JALR resolved
branch_finish  in  1  conditional branch committed
next_pc_from_rob  in  32  correct next PC (JALR target, or branch target/fallthrough)
branch_pc_from_rob  in  32  address of committed branch
prejudge  in  1  prediction that was made
branch_result  in  1  actual outcome

Behaviour:
- Reset: pc=RESET_PC; all cache valid bits 0; all outputs 0; state FETCH.
- rdy_in low: no state changes; outputs hold.
- Cache: index pc[2+CACHE_WIDTH-1:2], tag pc[31:2+CACHE_WIDTH].
  - Hit: instruction available to the fetch sequencer the cycle after lookup.
  - Miss: raise icache_to_memctrl with address=pc, held until received=1; wait for memctrl_to_icache; write line (valid, tag, data) and return data.
  - One outstanding miss at a time.
- States:
  - FETCH: lookup pc, wait for instruction. On instruction, predecode opcode inst[6:0]:
    - 1101111 JAL: next pc = pc + sign-extended J-immediate.
    - 1100011 branch: query=1 with pc_to_predictor=pc in this cycle; predict_result=predict; next pc = predict ? pc + B-immediate : pc+4.
    - 1100111 JALR: next pc unknown; after dispatch go to STALL.
    - All others: pc+4.
    - Go to DISPATCH.
  - DISPATCH: inst_valid=1 with inst/pc/predict_result stable until a posedge with dec_received=1. Then pc=next pc and go to FETCH (JALR: go to STALL).
  - STALL: no fetch until jalr_finish; then pc=next_pc_from_rob and go to FETCH.
- branch_finish (any state):
  - Always: update=1 for one cycle, update_pc=branch_pc_from_rob, update_result=branch_result.
  - If prejudge != branch_result (mispredict): inst_valid=0 next cycle; pc=next_pc_from_rob; state FETCH.
  - An in-flight miss completes on the memory side and still fills the cache, but its data is discarded by fetch.
- Same-cycle branch mispredict and jalr_finish: mispredict wins.
- Arithmetic: 32-bit wrap-around; immediates sign-extended from inst[31].
- Reset asserted mid-miss: drop request immediately; memctrl is reset concurrently.

Decomposition:
- Shared package: opcode constants (JAL, JALR, BRANCH), CACHE_WIDTH default, immediate-extraction functions (J-type and B-type).
- One sub-module, icache_dm: cache array plus the memctrl miss handshake. The sequencer and predecoder stay in the top module.

Test Plan:
- Cold start: memory[0]=0x00000013; miss at address 0 → icache_to_memctrl held until received, then inst_valid with inst=0x00000013, pc_to_decoder=0; after dec_received, fetch at pc 4.
- Loop re-executing PC 0x10 (0x00000013): second fetch hits, with no icache_to_memctrl activity and inst_valid one cycle after lookup.
- JAL 0x0080006F at pc 0x20: next fetch address is 0x28.
- BEQ at 0x40 with B-imm +16 and predict=1:
  - query=1 with pc_to_predictor=0x40; predict_result=1; next fetch 0x50.
  - Then branch_finish, prejudge=1, branch_result=0, branch_pc_from_rob=0x40, next_pc_from_rob=0x44 → update pulse (update_pc=0x40, update_result=0); inst_valid drops; fetch restarts at 0x44.
- JALR at 0x60: dispatched, then no fetch until jalr_finish with next_pc_from_rob=0x100; next fetch 0x100.
- rdy_in low for 5 cycles during a miss: all outputs and pc frozen; resumes identically. Reset pulse mid-miss: request drops and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_frontend_pkg.sv
// Shared definitions for the fetch front end: control-flow opcodes, cache geometry
// default, sequencer states and RV32I immediate extraction helpers.
package fetch_frontend_pkg;

    localparam int CACHE_WIDTH_DEF = 3;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DISPATCH,
        ST_STALL
    } fetch_state_e;

    function automatic logic [31:0] immJ(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] immB(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_frontend_icache.sv
// Direct-mapped instruction cache (one word per line) with a single outstanding
// miss towards memctrl. A flushed miss still fills its line but is not returned.
module icache_dm
    import fetch_frontend_pkg::*;
#(
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rdy_i,
    input  logic        lookup_i,
    input  logic [29:0] word_addr_i,
    input  logic        flush_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_received_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i
);

    localparam int LINES = 1 << CACHE_WIDTH;
    localparam int TAG_W = 30 - CACHE_WIDTH;

    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [31:0]            data_q [LINES];
    logic                   reqValid_q;
    logic [29:0]            reqAddr_q;
    logic                   busy_q;
    logic                   stale_q;

    logic [CACHE_WIDTH-1:0] lookupIdx;
    logic [TAG_W-1:0]       lookupTag;
    logic [CACHE_WIDTH-1:0] fillIdx;
    logic [TAG_W-1:0]       fillTag;
    logic                   hit;
    logic                   fill;

    assign lookupIdx  = word_addr_i[CACHE_WIDTH-1:0];
    assign lookupTag  = word_addr_i[29:CACHE_WIDTH];
    assign fillIdx    = reqAddr_q[CACHE_WIDTH-1:0];
    assign fillTag    = reqAddr_q[29:CACHE_WIDTH];
    assign hit        = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    assign fill       = busy_q && mem_valid_i;
    assign mem_req_o  = reqValid_q;
    assign mem_addr_o = {reqAddr_q, 2'b00};

    // While a miss is outstanding the lookup address is the miss address, unless a
    // flush has since redirected fetch, in which case the returning word is stale.
    always_comb begin
        resp_valid_o = 1'b0;
        resp_data_o  = data_q[lookupIdx];
        if (rdy_i && lookup_i) begin
            if (busy_q) begin
                if (fill && !stale_q) begin
                    resp_valid_o = 1'b1;
                    resp_data_o  = mem_data_i;
                end
            end else if (hit) begin
                resp_valid_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            reqValid_q <= 1'b0;
            reqAddr_q  <= '0;
            busy_q     <= 1'b0;
            stale_q    <= 1'b0;
        end else if (rdy_i) begin
            if (reqValid_q && mem_received_i) begin
                reqValid_q <= 1'b0;
            end
            if (fill) begin
                busy_q           <= 1'b0;
                stale_q          <= 1'b0;
                valid_q[fillIdx] <= 1'b1;
            end else if (busy_q && flush_i) begin
                stale_q <= 1'b1;
            end
            if (!busy_q && lookup_i && !hit && !flush_i) begin
                reqValid_q <= 1'b1;
                reqAddr_q  <= word_addr_i;
                busy_q     <= 1'b1;
                stale_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rdy_i && fill) begin
            tag_q[fillIdx]  <= fillTag;
            data_q[fillIdx] <= mem_data_i;
        end
    end

endmodule

// File: rtl/fetch_frontend.sv
// Fetch sequencer and control-flow predecoder: walks the PC through the icache,
// consults the branch predictor and hands one instruction at a time to decode.
module fetch_frontend
    import fetch_frontend_pkg::*;
#(
    parameter int          CACHE_WIDTH = CACHE_WIDTH_DEF,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_to_memctrl,
    output logic [31:0] address,
    input  logic        received,
    input  logic        memctrl_to_icache,
    input  logic [31:0] inst_in,
    output logic        query,
    output logic [31:0] pc_to_predictor,
    input  logic        predict,
    output logic        update,
    output logic [31:0] update_pc,
    output logic        update_result,
    output logic [31:0] inst,
    output logic [31:0] pc_to_decoder,
    output logic        inst_valid,
    output logic        predict_result,
    input  logic        dec_received,
    input  logic        jalr_finish,
    input  logic        branch_finish,
    input  logic [31:0] next_pc_from_rob,
    input  logic [31:0] branch_pc_from_rob,
    input  logic        prejudge,
    input  logic        branch_result
);

    fetch_state_e state_q;
    logic [31:0]  fetchPc_q;
    logic [31:0]  nextPc_q;
    logic [31:0]  decInst_q;
    logic [31:0]  decPc_q;
    logic         decPred_q;
    logic         instValid_q;
    logic         dispJalr_q;
    logic         update_q;
    logic [31:0]  updatePc_q;
    logic         updateResult_q;

    logic         respValid;
    logic [31:0]  respData;
    logic         lookup;
    logic         mispredict;
    logic [6:0]   opcode;
    logic         isBranch;
    logic [31:0]  seqNextPc;

    assign mispredict = branch_finish && (prejudge != branch_result);
    assign lookup     = (state_q == ST_FETCH) && !mispredict;
    assign opcode     = respData[6:0];
    assign isBranch   = respValid && (opcode == OPC_BRANCH);

    icache_dm #(
        .CACHE_WIDTH(CACHE_WIDTH)
    ) u_icache (
        .clk_i         (clk_in),
        .rst_ni        (rst_in),
        .rdy_i         (rdy_in),
        .lookup_i      (lookup),
        .word_addr_i   (fetchPc_q[31:2]),
        .flush_i       (mispredict),
        .resp_valid_o  (respValid),
        .resp_data_o   (respData),
        .mem_req_o     (icache_to_memctrl),
        .mem_addr_o    (address),
        .mem_received_i(received),
        .mem_valid_i   (memctrl_to_icache),
        .mem_data_i    (inst_in)
    );

    always_comb begin
        seqNextPc = fetchPc_q + 32'd4;
        if (opcode == OPC_JAL) begin
            seqNextPc = fetchPc_q + immJ(respData);
        end else if (isBranch && predict) begin
            seqNextPc = fetchPc_q + immB(respData);
        end
    end

    assign query           = isBranch;
    assign pc_to_predictor = fetchPc_q;
    assign update          = update_q;
    assign update_pc       = updatePc_q;
    assign update_result   = updateResult_q;
    assign inst            = decInst_q;
    assign pc_to_decoder   = decPc_q;
    assign inst_valid      = instValid_q;
    assign predict_result  = decPred_q;

    // A mispredict overrides whatever the sequencer was doing, including a JALR resolve.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_FETCH;
            fetchPc_q      <= RESET_PC;
            nextPc_q       <= '0;
            decInst_q      <= '0;
            decPc_q        <= '0;
            decPred_q      <= 1'b0;
            instValid_q    <= 1'b0;
            dispJalr_q     <= 1'b0;
            update_q       <= 1'b0;
            updatePc_q     <= '0;
            updateResult_q <= 1'b0;
        end else if (rdy_in) begin
            update_q <= branch_finish;
            if (branch_finish) begin
                updatePc_q     <= branch_pc_from_rob;
                updateResult_q <= branch_result;
            end
            if (mispredict) begin
                instValid_q <= 1'b0;
                fetchPc_q   <= next_pc_from_rob;
                state_q     <= ST_FETCH;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (respValid) begin
                            decInst_q   <= respData;
                            decPc_q     <= fetchPc_q;
                            decPred_q   <= isBranch && predict;
                            instValid_q <= 1'b1;
                            nextPc_q    <= seqNextPc;
                            dispJalr_q  <= (opcode == OPC_JALR);
                            state_q     <= ST_DISPATCH;
                        end
                    end
                    ST_DISPATCH: begin
                        if (dec_received) begin
                            instValid_q <= 1'b0;
                            if (dispJalr_q) begin
                                state_q <= ST_STALL;
                            end else begin
                                fetchPc_q <= nextPc_q;
                                state_q   <= ST_FETCH;
                            end
                        end
                    end
                    ST_STALL: begin
                        if (jalr_finish) begin
                            fetchPc_q <= next_pc_from_rob;
                            state_q   <= ST_FETCH;
                        end
                    end
                    default: state_q <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_frontend.sv
// Directed bench for fetch_frontend: plays memctrl, predictor and ROB by hand and
// checks each step against hand-computed values.
module tb_fetch_frontend;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        icache_to_memctrl;
    logic [31:0] address;
    logic        received = 1'b0;
    logic        memctrl_to_icache = 1'b0;
    logic [31:0] inst_in = '0;
    logic        query;
    logic [31:0] pc_to_predictor;
    logic        predict = 1'b0;
    logic        update;
    logic [31:0] update_pc;
    logic        update_result;
    logic [31:0] inst;
    logic [31:0] pc_to_decoder;
    logic        inst_valid;
    logic        predict_result;
    logic        dec_received = 1'b0;
    logic        jalr_finish = 1'b0;
    logic        branch_finish = 1'b0;
    logic [31:0] next_pc_from_rob = '0;
    logic [31:0] branch_pc_from_rob = '0;
    logic        prejudge = 1'b0;
    logic        branch_result = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_M4   = 32'hFFDF_F06F;
    localparam logic [31:0] JAL_P8   = 32'h0080_006F;
    localparam logic [31:0] JAL_P24  = 32'h0180_006F;
    localparam logic [31:0] JAL_P28  = 32'h01C0_006F;
    localparam logic [31:0] BEQ_P16  = 32'h0000_0863;
    localparam logic [31:0] JALR_X1  = 32'h0000_8067;

    fetch_frontend dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .icache_to_memctrl (icache_to_memctrl),
        .address           (address),
        .received          (received),
        .memctrl_to_icache (memctrl_to_icache),
        .inst_in           (inst_in),
        .query             (query),
        .pc_to_predictor   (pc_to_predictor),
        .predict           (predict),
        .update            (update),
        .update_pc         (update_pc),
        .update_result     (update_result),
        .inst              (inst),
        .pc_to_decoder     (pc_to_decoder),
        .inst_valid        (inst_valid),
        .predict_result    (predict_result),
        .dec_received      (dec_received),
        .jalr_finish       (jalr_finish),
        .branch_finish     (branch_finish),
        .next_pc_from_rob  (next_pc_from_rob),
        .branch_pc_from_rob(branch_pc_from_rob),
        .prejudge          (prejudge),
        .branch_result     (branch_result)
    );

    always #5 clk_in = ~clk_in;

    task automatic applyStimulus();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Serve one miss as memctrl and check the resulting dispatch.
    task automatic fetchMiss(input string tag, input logic [31:0] expPc, input logic [31:0] word,
                             input logic expQuery, input logic pred);
        int n = 0;
        while (!icache_to_memctrl && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_req"}, {31'b0, icache_to_memctrl}, 32'd1);
        checkOutput({tag, "_addr"}, address, expPc);
        received = 1'b1;
        applyStimulus();
        received = 1'b0;
        checkOutput({tag, "_reqdrop"}, {31'b0, icache_to_memctrl}, 32'd0);
        memctrl_to_icache = 1'b1;
        inst_in = word;
        predict = pred;
        #1;
        checkOutput({tag, "_query"}, {31'b0, query}, {31'b0, expQuery});
        if (expQuery) checkOutput({tag, "_qpc"}, pc_to_predictor, expPc);
        applyStimulus();
        memctrl_to_icache = 1'b0;
        predict = 1'b0;
        checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        checkOutput({tag, "_inst"}, inst, word);
        checkOutput({tag, "_pc"}, pc_to_decoder, expPc);
        checkOutput({tag, "_pred"}, {31'b0, predict_result}, {31'b0, expQuery && pred});
    endtask

    task automatic acceptInst(input string tag);
        dec_received = 1'b1;
        applyStimulus();
        dec_received = 1'b0;
        checkOutput({tag, "_accdrop"}, {31'b0, inst_valid}, 32'd0);
    endtask

    initial begin
        applyStimulus();
        applyStimulus();
        checkOutput("rst_req", {31'b0, icache_to_memctrl}, 32'd0);
        checkOutput("rst_addr", address, 32'd0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_pcdec", pc_to_decoder, 32'd0);
        checkOutput("rst_update", {31'b0, update}, 32'd0);
        checkOutput("rst_query", {31'b0, query}, 32'd0);
        rst_in = 1'b1;

        // Cold start: request held until received.
        applyStimulus();
        checkOutput("cold_req", {31'b0, icache_to_memctrl}, 32'd1);
        applyStimulus();
        applyStimulus();
        checkOutput("cold_hold", {31'b0, icache_to_memctrl}, 32'd1);
        fetchMiss("cold", 32'h0, NOP, 1'b0, 1'b0);
        acceptInst("cold");
        applyStimulus();
        checkOutput("pc4_req", {31'b0, icache_to_memctrl}, 32'd1);
        checkOutput("pc4_addr", address, 32'h4);

        fetchMiss("f04", 32'h04, NOP, 1'b0, 1'b0);
        acceptInst("f04");
        fetchMiss("f08", 32'h08, NOP, 1'b0, 1'b0);
        acceptInst("f08");
        fetchMiss("f0c", 32'h0C, NOP, 1'b0, 1'b0);
        acceptInst("f0c");
        fetchMiss("f10", 32'h10, NOP, 1'b0, 1'b0);
        acceptInst("f10");
        fetchMiss("f14", 32'h14, JAL_M4, 1'b0, 1'b0);
        acceptInst("f14");

        // Loop back to 0x10 must hit.
        checkOutput("hit_noreq0", {31'b0, icache_to_memctrl}, 32'd0);
        applyStimulus();
        checkOutput("hit_noreq1", {31'b0, icache_to_memctrl}, 32'd0);
        checkOutput("hit_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("hit_pc", pc_to_decoder, 32'h10);
        checkOutput("hit_inst", inst, NOP);

        // Redirect from dispatch by a mispredicted branch report.
        branch_finish = 1'b1;
        prejudge = 1'b0;
        branch_result = 1'b1;
        branch_pc_from_rob = 32'h80;
        next_pc_from_rob = 32'h20;
        applyStimulus();
        branch_finish = 1'b0;
        checkOutput("redir_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("redir_upd", {31'b0, update}, 32'd1);
        checkOutput("redir_updres", {31'b0, update_result}, 32'd1);

        fetchMiss("jal", 32'h20, JAL_P8, 1'b0, 1'b0);
        acceptInst("jal");
        fetchMiss("f28", 32'h28, JAL_P24, 1'b0, 1'b0);
        acceptInst("f28");

        // Predicted-taken BEQ, then mispredict while the 0x50 miss is in flight.
        fetchMiss("beq", 32'h40, BEQ_P16, 1'b1, 1'b1);
        acceptInst("beq");
        applyStimulus();
        checkOutput("beq_tgt_req", {31'b0, icache_to_memctrl}, 32'd1);
        checkOutput("beq_tgt_addr", address, 32'h50);
        branch_finish = 1'b1;
        prejudge = 1'b1;
        branch_result = 1'b0;
        branch_pc_from_rob = 32'h40;
        next_pc_from_rob = 32'h44;
        applyStimulus();
        branch_finish = 1'b0;
        checkOutput("mp_upd", {31'b0, update}, 32'd1);
        checkOutput("mp_updpc", update_pc, 32'h40);
        checkOutput("mp_updres", {31'b0, update_result}, 32'd0);
        checkOutput("mp_valid", {31'b0, inst_valid}, 32'd0);
        applyStimulus();
        checkOutput("mp_updpulse", {31'b0, update}, 32'd0);
        received = 1'b1;
        applyStimulus();
        received = 1'b0;
        memctrl_to_icache = 1'b1;
        inst_in = 32'hDEAD_BEEF;
        applyStimulus();
        memctrl_to_icache = 1'b0;
        checkOutput("stale_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("stale_noreq", {31'b0, icache_to_memctrl}, 32'd0);

        fetchMiss("f44", 32'h44, JAL_P28, 1'b0, 1'b0);
        acceptInst("f44");

        // JALR stalls fetch until the ROB resolves it.
        fetchMiss("jalr", 32'h60, JALR_X1, 1'b0, 1'b0);
        acceptInst("jalr");
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("stall_noreq", {31'b0, icache_to_memctrl}, 32'd0);
        checkOutput("stall_valid", {31'b0, inst_valid}, 32'd0);
        jalr_finish = 1'b1;
        next_pc_from_rob = 32'h100;
        applyStimulus();
        jalr_finish = 1'b0;
        applyStimulus();
        checkOutput("jalr_req", {31'b0, icache_to_memctrl}, 32'd1);
        checkOutput("jalr_addr", address, 32'h100);

        // Freeze mid-miss; a received pulse while frozen must be ignored.
        rdy_in = 1'b0;
        received = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("frz_req", {31'b0, icache_to_memctrl}, 32'd1);
            checkOutput("frz_addr", address, 32'h100);
            checkOutput("frz_valid", {31'b0, inst_valid}, 32'd0);
        end
        received = 1'b0;
        rdy_in = 1'b1;
        fetchMiss("f100", 32'h100, NOP, 1'b0, 1'b0);
        acceptInst("f100");

        // Reset during a miss drops the request at once and restarts at RESET_PC.
        applyStimulus();
        checkOutput("f104_addr", address, 32'h104);
        rst_in = 1'b0;
        #1;
        checkOutput("rst_drop", {31'b0, icache_to_memctrl}, 32'd0);
        applyStimulus();
        rst_in = 1'b1;
        applyStimulus();
        checkOutput("rst_req2", {31'b0, icache_to_memctrl}, 32'd1);
        checkOutput("rst_addr2", address, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
